// File: rtl/systolic_array_os_rect_if.sv
// Purpose: operand-beat and result-row handshake bundle for systolic_array_os_rect.
// Ports: in_valid/in_ready/a_in/b_in carry one operand beat; out_valid/out_ready/out_row/out_row_idx carry one result row.
// Modports: master = upstream producer / downstream consumer side, slave = the array itself.
interface systolic_array_os_rect_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [ROWS*DATA_WIDTH-1:0]  a_in;
    logic [COLS*DATA_WIDTH-1:0]  b_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [COLS*ACC_WIDTH-1:0]   out_row;
    logic [$clog2(ROWS):0]       out_row_idx;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_row, out_row_idx
    );
endinterface

// File: rtl/systolic_array_os_rect.sv
// Purpose: ROWS x COLS output-stationary signed MAC array; A flows right, B flows down, rows drained top-first.
// Latency: first result row is presented ROWS+COLS cycles after the last operand beat is accepted.
// Backpressure: in_ready only while beats remain in COMPUTE; out_ready low freezes the presented row and index.
// Ports: core_clk, resetn (sync, active low), start/k_len (job request), busy, done, bus (slave modport).
// Option: define SYSTOLIC_OS_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module systolic_array_os_rect #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic                 core_clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k_len,
    output logic                 busy,
    output logic                 done,
    systolic_array_os_rect_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam int FW = $clog2(ROWS + COLS) + 1;
    localparam int IW = $clog2(ROWS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_t;

    state_t               state_q;
    logic [K_WIDTH-1:0]   k_q;
    logic [K_WIDTH-1:0]   beat_cnt_q;
    logic [FW-1:0]        flush_cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 beat_acc;
    logic                 drain_hs;

    logic [DATA_WIDTH-1:0] a_at  [ROWS][COLS];
    logic                  a_vat [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_at  [ROWS][COLS];
    logic                  b_vat [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];

    assign beat_acc = bus.in_valid && in_ready_q;
    assign drain_hs = out_valid_q && bus.out_ready;

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row_idx = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;

    // Skew and forwarding merged into one delay line per lane: tap r+c of row
    // lane r is the A operand seen by PE(r,c) (r cycles skew + c hops right).
    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        localparam int LEN = r + COLS;
        logic [DATA_WIDTH-1:0] dat_q [LEN];
        logic                  vld_q [LEN];
        always_ff @(posedge core_clk) begin
            if (!resetn) begin
                for (int i = 0; i < LEN; i++) begin
                    dat_q[i] <= '0;
                    vld_q[i] <= 1'b0;
                end
            end else begin
                dat_q[0] <= bus.a_in[r*DATA_WIDTH +: DATA_WIDTH];
                vld_q[0] <= beat_acc;
                for (int i = 1; i < LEN; i++) begin
                    dat_q[i] <= dat_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
        for (genvar c = 0; c < COLS; c++) begin : g_tap
            assign a_at[r][c]  = dat_q[r+c];
            assign a_vat[r][c] = vld_q[r+c];
        end
    end

    // Column lane c: tap c+r is the B operand seen by PE(r,c).
    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        localparam int LEN = c + ROWS;
        logic [DATA_WIDTH-1:0] dat_q [LEN];
        logic                  vld_q [LEN];
        always_ff @(posedge core_clk) begin
            if (!resetn) begin
                for (int i = 0; i < LEN; i++) begin
                    dat_q[i] <= '0;
                    vld_q[i] <= 1'b0;
                end
            end else begin
                dat_q[0] <= bus.b_in[c*DATA_WIDTH +: DATA_WIDTH];
                vld_q[0] <= beat_acc;
                for (int i = 1; i < LEN; i++) begin
                    dat_q[i] <= dat_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
        for (genvar r = 0; r < ROWS; r++) begin : g_tap
            assign b_at[r][c]  = dat_q[c+r];
            assign b_vat[r][c] = vld_q[c+r];
        end
    end

    function automatic logic [ACC_WIDTH-1:0] mac(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [PW-1:0] prod_d;
        logic [SW-1:0] sum_d;
        prod_d = PW'($signed(a)) * PW'($signed(b));
        // One guard bit above the accumulator exposes signed overflow.
        sum_d  = SW'($signed(acc)) + SW'($signed(prod_d));
`ifdef SYSTOLIC_OS_SAT_EN
        if (sum_d[SW-1] != sum_d[SW-2])
            mac = sum_d[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            mac = sum_d[ACC_WIDTH-1:0];
`else
        mac = sum_d[ACC_WIDTH-1:0] | {ACC_WIDTH{sum_d[SW-1] & 1'b0}};
`endif
    endfunction

    // PEs only see valid operands outside DRAIN, so the row shift never
    // collides with an accumulation.
    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    acc_q[r][c] <= '0;
        end else if (drain_hs) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    acc_q[r][c] <= acc_q[r+1][c];
            for (int c = 0; c < COLS; c++)
                acc_q[ROWS-1][c] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (a_vat[r][c] && b_vat[r][c])
                        acc_q[r][c] <= mac(acc_q[r][c], a_at[r][c], b_at[r][c]);
        end
    end

    always_comb begin
        bus.out_row = '0;
        for (int c = 0; c < COLS; c++)
            bus.out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[0][c];
    end

    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_COMPUTE;
                        k_q        <= k_len;
                        beat_cnt_q <= '0;
                        in_ready_q <= (k_len != '0);
                        busy_q     <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (k_q == '0) begin
                        state_q     <= S_FLUSH;
                        flush_cnt_q <= '0;
                    end else if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
                        if (beat_cnt_q == k_q - K_WIDTH'(1)) begin
                            state_q     <= S_FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    // ROWS+COLS-1 cycles lets the farthest PE consume the last beat.
                    if (flush_cnt_q == FW'(ROWS + COLS - 2)) begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (idx_q == IW'(ROWS - 1)) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_os_rect.sv
// Purpose: directed self-checking bench for systolic_array_os_rect (4x4, 2x3 and 2x2/16-bit instances).
// Latency: checks first-row timing against ROWS+COLS after the last accepted beat.
// Backpressure: exercises input bubbles, output stalls, start while busy and reset mid-drain.
module tb_systolic_array_os_rect;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 6;
    localparam int NV = 5;

    typedef struct packed {
        logic [7:0]                  k;
        logic                        bubbles;
        logic                        stall;
        logic                        poke;
        logic [R-1:0][KM-1:0][DW-1:0] a;
        logic [KM-1:0][C-1:0][DW-1:0] b;
        logic [R-1:0][C-1:0][AW-1:0]  ex;
    } vec_t;

    logic core_clk = 1'b0;
    logic resetn   = 1'b0;
    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs [NV];

    // 4x4 instance
    logic       st0, busy0, done0;
    logic [7:0] kl0;
    systolic_array_os_rect_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C)) if0 ();
    systolic_array_os_rect #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_WIDTH(8)) dut0 (
        .core_clk(core_clk), .resetn(resetn), .start(st0), .k_len(kl0),
        .busy(busy0), .done(done0), .bus(if0)
    );

    // 2x3 rectangular instance
    logic       st1, busy1, done1;
    logic [7:0] kl1;
    systolic_array_os_rect_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(2), .COLS(3)) if1 ();
    systolic_array_os_rect #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(2), .COLS(3), .K_WIDTH(8)) dut1 (
        .core_clk(core_clk), .resetn(resetn), .start(st1), .k_len(kl1),
        .busy(busy1), .done(done1), .bus(if1)
    );

    // 2x2 instance with a 16-bit accumulator
    logic       st2, busy2, done2;
    logic [7:0] kl2;
    systolic_array_os_rect_if #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .ROWS(2), .COLS(2)) if2 ();
    systolic_array_os_rect #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .ROWS(2), .COLS(2), .K_WIDTH(8)) dut2 (
        .core_clk(core_clk), .resetn(resetn), .start(st2), .k_len(kl2),
        .busy(busy2), .done(done2), .bus(if2)
    );

    int a1  [4][2] = '{'{1, -1}, '{2, 0}, '{0, 3}, '{-2, 1}};
    int e1  [4][4] = '{'{-4, -4, -4, -4}, '{2, 4, 6, 8}, '{15, 18, 21, 24}, '{3, 2, 1, 0}};
    int ra  [2][2] = '{'{1, 2}, '{3, 4}};
    int rb  [2][3] = '{'{5, 6, 7}, '{8, 9, 10}};
    int rex [2][3] = '{'{21, 24, 27}, '{47, 54, 61}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one job on the 4x4 instance; abort_row >= 0 applies reset instead
    // of accepting that row.
    task automatic run_job(input vec_t v, input int abort_row);
        int n;
        int last_acc;
        @(negedge core_clk);
        st0 = 1'b1;
        kl0 = v.k;
        @(negedge core_clk);
        st0 = 1'b0;
        kl0 = 8'd0;
        check("busy_after_start", 128'(busy0), 128'(1));
        last_acc = cyc;
        for (int j = 0; j < int'(v.k); j++) begin
            if (v.bubbles) begin
                if0.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge core_clk);
            end
            for (int r = 0; r < R; r++) if0.a_in[r*DW +: DW] = v.a[r][j];
            if0.b_in = v.b[j];
            if0.in_valid = 1'b1;
            n = 0;
            while (!if0.in_ready && n < 20) begin
                @(negedge core_clk);
                n++;
            end
            check("beat_in_ready", 128'(if0.in_ready), 128'(1));
            last_acc = cyc;
            @(negedge core_clk);
            if0.in_valid = 1'b0;
            if (v.poke && j == 0) begin
                st0 = 1'b1;
                kl0 = 8'd1;
                @(negedge core_clk);
                st0 = 1'b0;
                kl0 = 8'd0;
            end
        end
        check("in_ready_after_beats", 128'(if0.in_ready), 128'(0));
        n = 0;
        while (!if0.out_valid && n < 100) begin
            @(negedge core_clk);
            n++;
        end
        check("out_valid_rise", 128'(if0.out_valid), 128'(1));
        if (v.k != 8'd0) check("first_row_latency", 128'(cyc - last_acc), 128'(R + C));
        for (int r = 0; r < R; r++) begin
            n = 0;
            while (!if0.out_valid && n < 20) begin
                @(negedge core_clk);
                n++;
            end
            if (r == abort_row) begin
                resetn = 1'b0;
                @(negedge core_clk);
                check("abort_busy", 128'(busy0), 128'(0));
                check("abort_done", 128'(done0), 128'(0));
                check("abort_out_valid", 128'(if0.out_valid), 128'(0));
                resetn = 1'b1;
                @(negedge core_clk);
                check("abort_no_late_done", 128'(done0), 128'(0));
                return;
            end
            if (v.stall) begin
                if0.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge core_clk);
                    check($sformatf("stall_row%0d", r), 128'(if0.out_row), 128'(v.ex[r]));
                    check($sformatf("stall_idx%0d", r), 128'(if0.out_row_idx), 128'(r));
                end
            end
            check($sformatf("row%0d_valid", r), 128'(if0.out_valid), 128'(1));
            check($sformatf("row%0d_data", r), 128'(if0.out_row), 128'(v.ex[r]));
            check($sformatf("row%0d_idx", r), 128'(if0.out_row_idx), 128'(r));
            if0.out_ready = 1'b1;
            @(negedge core_clk);
            if0.out_ready = 1'b0;
        end
        check("done_pulse", 128'(done0), 128'(1));
        check("busy_cleared", 128'(busy0), 128'(0));
        check("acc_cleared", 128'(if0.out_row), 128'(0));
        @(negedge core_clk);
        check("done_single", 128'(done0), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        logic [3*AW-1:0] er1;
        logic [15:0]     esat;

        st0 = 1'b0; kl0 = '0; if0.in_valid = 1'b0; if0.a_in = '0; if0.b_in = '0; if0.out_ready = 1'b0;
        st1 = 1'b0; kl1 = '0; if1.in_valid = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.out_ready = 1'b0;
        st2 = 1'b0; kl2 = '0; if2.in_valid = 1'b0; if2.a_in = '0; if2.b_in = '0; if2.out_ready = 1'b0;

        // 0: identity A, B = 1..16 -> rows of B
        // 1: mixed signs, k=2, with bubbles, stalls and start while busy
        // 2: k=0 -> four zero rows
        // 3: k=6, all operands -128 -> 6*16384 = 98304
        // 4: k=1, A=1, B=2 -> all 2 (used after the mid-drain reset)
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[0].k = 8'd4;
        for (int r = 0; r < R; r++)
            for (int j = 0; j < 4; j++) begin
                vecs[0].a[r][j] = (r == j) ? 8'd1 : 8'd0;
                vecs[0].b[r][j] = 8'(r * 4 + j + 1);
                vecs[0].ex[r][j] = 32'(r * 4 + j + 1);
            end
        vecs[1].k = 8'd2; vecs[1].bubbles = 1'b1; vecs[1].stall = 1'b1; vecs[1].poke = 1'b1;
        for (int r = 0; r < R; r++) begin
            for (int j = 0; j < 2; j++) vecs[1].a[r][j] = 8'(a1[r][j]);
            for (int c = 0; c < C; c++) vecs[1].ex[r][c] = 32'(e1[r][c]);
        end
        for (int j = 0; j < 2; j++)
            for (int c = 0; c < C; c++) vecs[1].b[j][c] = 8'(j * 4 + c + 1);
        vecs[2].k = 8'd0;
        vecs[3].k = 8'd6; vecs[3].bubbles = 1'b1; vecs[3].stall = 1'b1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) vecs[3].ex[r][c] = 32'd98304;
        for (int r = 0; r < R; r++)
            for (int j = 0; j < KM; j++) begin
                vecs[3].a[r][j] = 8'h80;
                vecs[3].b[j][r] = 8'h80;
            end
        vecs[4].k = 8'd1;
        for (int r = 0; r < R; r++) begin
            vecs[4].a[r][0] = 8'd1;
            vecs[4].b[0][r] = 8'd2;
            for (int c = 0; c < C; c++) vecs[4].ex[r][c] = 32'd2;
        end

        resetn = 1'b0;
        repeat (3) @(negedge core_clk);
        check("rst_busy", 128'(busy0), 128'(0));
        check("rst_done", 128'(done0), 128'(0));
        check("rst_in_ready", 128'(if0.in_ready), 128'(0));
        check("rst_out_valid", 128'(if0.out_valid), 128'(0));
        check("rst_out_row", 128'(if0.out_row), 128'(0));
        check("rst_idx", 128'(if0.out_row_idx), 128'(0));
        resetn = 1'b1;

        for (int i = 0; i < NV - 1; i++) run_job(vecs[i], -1);

        // Rectangular 2x3: FLUSH of 4 cycles puts the first row 5 cycles after the last beat.
        @(negedge core_clk);
        st1 = 1'b1; kl1 = 8'd2;
        @(negedge core_clk);
        st1 = 1'b0; kl1 = 8'd0;
        last = cyc;
        for (int j = 0; j < 2; j++) begin
            for (int r = 0; r < 2; r++) if1.a_in[r*DW +: DW] = 8'(ra[r][j]);
            for (int c = 0; c < 3; c++) if1.b_in[c*DW +: DW] = 8'(rb[j][c]);
            if1.in_valid = 1'b1;
            n = 0;
            while (!if1.in_ready && n < 20) begin
                @(negedge core_clk);
                n++;
            end
            check("rect_beat_ready", 128'(if1.in_ready), 128'(1));
            last = cyc;
            @(negedge core_clk);
        end
        if1.in_valid = 1'b0;
        n = 0;
        while (!if1.out_valid && n < 100) begin
            @(negedge core_clk);
            n++;
        end
        check("rect_out_valid", 128'(if1.out_valid), 128'(1));
        check("rect_latency", 128'(cyc - last), 128'(5));
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) er1[c*AW +: AW] = 32'(rex[r][c]);
            check($sformatf("rect_row%0d", r), 128'(if1.out_row), 128'(er1));
            check($sformatf("rect_idx%0d", r), 128'(if1.out_row_idx), 128'(r));
            if1.out_ready = 1'b1;
            @(negedge core_clk);
        end
        if1.out_ready = 1'b0;
        check("rect_done", 128'(done1), 128'(1));
        check("rect_busy", 128'(busy1), 128'(0));

        // 16-bit accumulator, four beats of 127*127 = 16129 each.
`ifdef SYSTOLIC_OS_SAT_EN
        esat = 16'h7FFF;
`else
        esat = 16'hFC04;
`endif
        @(negedge core_clk);
        st2 = 1'b1; kl2 = 8'd4;
        @(negedge core_clk);
        st2 = 1'b0; kl2 = 8'd0;
        if2.a_in = {8'd127, 8'd127};
        if2.b_in = {8'd127, 8'd127};
        for (int j = 0; j < 4; j++) begin
            if2.in_valid = 1'b1;
            n = 0;
            while (!if2.in_ready && n < 20) begin
                @(negedge core_clk);
                n++;
            end
            check("sat_beat_ready", 128'(if2.in_ready), 128'(1));
            @(negedge core_clk);
        end
        if2.in_valid = 1'b0;
        n = 0;
        while (!if2.out_valid && n < 100) begin
            @(negedge core_clk);
            n++;
        end
        for (int r = 0; r < 2; r++) begin
            check($sformatf("sat_row%0d", r), 128'(if2.out_row), 128'({esat, esat}));
            if2.out_ready = 1'b1;
            @(negedge core_clk);
        end
        if2.out_ready = 1'b0;
        check("sat_done", 128'(done2), 128'(1));

        // Reset after two rows of an identity job, then a fresh k=1 job.
        run_job(vecs[0], 2);
        run_job(vecs[NV-1], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_array_os_rect.md
SYSTOLIC_ARRAY_OS_RECT -- requirements
Module: systolic_array_os_rect

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width; must be >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter ROWS, default 4, PE rows (A lanes); range 1..16.
REQ-004 SHALL have parameter COLS, default 4, PE columns (B lanes); range 1..16.
REQ-005 SHALL have parameter K_WIDTH, default 8, width of the reduction-length field.
REQ-006 SHALL use one clock and a synchronous active-low reset: core_clk input 1, clock; resetn input 1, synchronous active-low reset.
REQ-007 SHALL have start input 1, a one-cycle request to begin a job; it is sampled only in IDLE.
REQ-008 SHALL have k_len input K_WIDTH, the reduction length, captured with start.
REQ-009 SHALL have in_valid input 1 and in_ready output 1, the operand beat handshake.
REQ-010 SHALL have a_in input ROWS*DATA_WIDTH, one A element per row lane.
REQ-011 SHALL have b_in input COLS*DATA_WIDTH, one B element per column lane.
REQ-012 SHALL have out_valid output 1 and out_ready input 1, the result row handshake.
REQ-013 SHALL have out_row output COLS*ACC_WIDTH, one accumulator row.
REQ-014 SHALL have out_row_idx output $clog2(ROWS)+1 bits, the index of the presented row.
REQ-015 SHALL have busy output 1, asserted when the FSM is not IDLE.
REQ-016 SHALL have done output 1, a one-cycle pulse after the last row is accepted.

Function
REQ-017 SHALL implement the FSM IDLE -> COMPUTE -> FLUSH -> DRAIN -> IDLE.
- IDLE -> COMPUTE on start.
- COMPUTE -> FLUSH on the cycle after beat k_len is accepted.
- COMPUTE -> FLUSH immediately if k_len=0.
REQ-018 SHALL drive in_ready=1 only in COMPUTE while the beat count < k_len; a beat is accepted when in_valid && in_ready.
REQ-019 SHALL skew an accepted beat internally: row lane r enters PE column 0 after r cycles; column lane c enters PE row 0 after c cycles; each lane carries a valid bit.
REQ-020 SHALL forward operand and valid one PE per cycle, right for A and down for B.
REQ-021 SHALL update each PE acc += a*b (signed, full product sign-extended to ACC_WIDTH) when both inputs are valid, and hold acc otherwise.
REQ-022 SHALL make in_valid=0 gaps propagate as bubbles, with no effect on results.
REQ-023 SHALL keep FLUSH for exactly ROWS+COLS-1 cycles, so the skew and pipeline empty.
REQ-024 SHALL, in DRAIN, assert out_valid with out_row = row out_row_idx, starting at index 0.
- On each out_valid && out_ready, the accumulator rows shift up by one, zeros enter the bottom row, and the index increments.
REQ-025 SHALL hold out_row and out_row_idx stable while out_valid && !out_ready.
REQ-026 SHALL, when row ROWS-1 is accepted, pulse done for one cycle and return to IDLE with all accumulators zero.
REQ-027 SHALL raise out_valid exactly ROWS+COLS cycles after the cycle the last beat is accepted, when k_len>0.
REQ-028 SHALL ignore start when not in IDLE.
REQ-029 SHALL drain ROWS all-zero rows when k_len=0.
REQ-030 SHALL support ROWS != COLS; the FLUSH count and skew use each dimension independently.

Reset
REQ-031 SHALL, while resetn=0 at a core_clk edge, set:
- FSM to IDLE;
- all accumulators, skew registers and PE valid bits to 0;
- the beat count and index to 0;
- in_ready, out_valid, busy and done to 0;
- out_row to 0.
REQ-032 SHALL abort the job on reset asserted mid-job in any state; no done pulse is produced.

Configuration
REQ-033 SHALL compile saturating accumulation when SYSTOLIC_OS_SAT_EN is defined: each update clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-034 SHALL, without SYSTOLIC_OS_SAT_EN, wrap accumulation modulo 2^ACC_WIDTH (two's complement).

Verification
REQ-035 SHALL cover identity: ROWS=COLS=4, k_len=4, A=I, B=[1..16] -> rows out as B row by row, done once, out_valid 8 cycles after the last beat.
REQ-036 SHALL cover a rectangular array: ROWS=2, COLS=3, k_len=2, A=[[1,2],[3,4]], B=[[5,6,7],[8,9,10]] -> rows [21,24,27], [47,54,61]; FLUSH lasts 4 cycles.
REQ-037 SHALL cover backpressure and bubbles: random in_valid gaps and out_ready low for 3 cycles per row -> results match the golden model; out_row stable while stalled.
REQ-038 SHALL cover the edge cases:
- k_len=0 -> 4 zero rows, then done.
- start during COMPUTE -> ignored.
REQ-039 SHALL cover saturation: DATA_WIDTH=8, ACC_WIDTH=16, k_len=4, all operands 127 -> 32767 with SYSTOLIC_OS_SAT_EN, 64516 mod 2^16 = -1020 without.
REQ-040 SHALL cover reset mid-DRAIN after row 1 -> busy=0 next cycle, no done; a following job with k_len=1, A=1, B=2 -> all rows 2.
